// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Fetch stage in front of decode. Owns the PC and issues word reads to
// instruction memory over a req/gnt/rvalid handshake. Returned words go into
// a small prefetch FIFO, and the head of that FIFO is what decode sees.
// Redirects from decode (taken branch or jal) move the PC and flush the FIFO.
// They also drop every read that was already in flight.
//
// Ports
//   clk, reset    clock, asynchronous active-high reset
//   stallD        decode stall; the FIFO head is held, not consumed
//   pcsrcD        taken branch in decode, target pcbranchD
//   jumpD         jal in decode, target {pcplus4D[31:28], jumpdstD}
//   imem_req      read request valid, with imem_addr (held until imem_gnt)
//   imem_gnt      memory accepts the request this cycle
//   imem_rvalid   read data valid (in issue order), with imem_rdata
//   instrF        instruction to decode; 0 (nop) when empty or redirecting
//   pcplus4F      PC+4 of instrF; 0 when instrF is a bubble
//   emptyF        prefetch FIFO is empty
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    input  logic [27:0] jumpdstD,
    input  logic [31:0] pcplus4D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrF,
    output logic [31:0] pcplus4F,
    output logic        emptyF
);

    localparam int          AW     = $clog2(DEPTH);
    localparam int          CW     = AW + 1;
    localparam logic [CW:0] DEPTHW = (CW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   dataMem [DEPTH];
    logic [31:0]   pcMem   [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic          redirect;
    logic [31:0]   target;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          empty;
    logic [CW-1:0] outstandingNext;
    logic [CW-1:0] liveInFlight;
    logic [31:0]   liveBytes;
    logic [31:0]   respPcPlus4;

    // Only the region bits of pcplus4D feed the jump target.
    logic          unusedPcBits;
    assign unusedPcBits = ^pcplus4D[27:0];

    // A stalled decode cannot redirect. The request is simply seen again
    // once the stall drops. jal wins over a branch in the same cycle.
    assign redirect = (jumpD | pcsrcD) & ~stallD;
    assign target   = jumpD ? {pcplus4D[31:28], jumpdstD} : pcbranchD;

    // Issue is limited by FIFO entries plus reads in flight. Every returning
    // word then has a slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = ~redirect & (occupancy < DEPTHW);
    assign imem_addr = pc;
    assign issue     = imem_req & imem_gnt;

    assign empty  = (count == '0);
    assign emptyF = empty;
    assign push   = imem_rvalid & ~redirect & (discard == '0);
    assign pop    = ~stallD & ~redirect & ~empty;

    assign outstandingNext = outstanding + CW'(issue) - CW'(imem_rvalid);

    // Reads still in flight that were issued after the last redirect form a
    // contiguous run ending just below pc. The oldest one is returning now,
    // so its address is pc minus four bytes per live read.
    assign liveInFlight = outstanding - discard;
    assign liveBytes    = {{(30 - CW){1'b0}}, liveInFlight, 2'b00};
    assign respPcPlus4  = pc - liveBytes + 32'd4;

    // Output the head, but force a bubble on the redirect cycle. For jal,
    // this kills the wrong-path slot that decode would not clear itself.
    assign instrF   = (~empty & ~redirect) ? dataMem[rdPtr] : 32'h0;
    assign pcplus4F = (~empty & ~redirect) ? pcMem[rdPtr]   : 32'h0;

    // Control state: PC, FIFO pointers and counters, and the count of stale
    // responses still to be dropped. On a redirect, everything in flight
    // becomes stale. A response arriving in that cycle is already dropped
    // and retired in outstandingNext.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (redirect) begin
                pc      <= target;
                rdPtr   <= '0;
                wrPtr   <= '0;
                count   <= '0;
                discard <= outstandingNext;
            end else begin
                if (issue) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rvalid && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    wrPtr <= wrPtr + 1'b1;
                end
                if (pop) begin
                    rdPtr <= rdPtr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage. Contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            dataMem[wrPtr] <= imem_rdata;
            pcMem[wrPtr]   <= respPcPlus4;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stallD;
    logic        pcsrcD;
    logic [31:0] pcbranchD;
    logic        jumpD;
    logic [27:0] jumpdstD;
    logic [31:0] pcplus4D;
    logic        imem_gnt;

    logic        imem_req,    req2;
    logic [31:0] imem_addr,   addr2;
    logic        imem_rvalid, rvalid2;
    logic [31:0] imem_rdata,  rdata2;
    logic [31:0] instrF,      instr2;
    logic [31:0] pcplus4F,    pcp2;
    logic        emptyF,      empty2;

    int assertCount = 0;
    int failCount   = 0;
    int latency     = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t q1[$];
    memReq_t q2[$];
    int      cyc = 0;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stallD(stallD), .pcsrcD(pcsrcD),
        .pcbranchD(pcbranchD), .jumpD(jumpD), .jumpdstD(jumpdstD),
        .pcplus4D(pcplus4D), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrF(instrF), .pcplus4F(pcplus4F), .emptyF(emptyF)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .clk(clk), .reset(reset), .stallD(stallD), .pcsrcD(pcsrcD),
        .pcbranchD(pcbranchD), .jumpD(jumpD), .jumpdstD(jumpdstD),
        .pcplus4D(pcplus4D), .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(imem_gnt), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .instrF(instr2), .pcplus4F(pcp2), .emptyF(empty2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // In-order memory models, one per instance. A read accepted at edge c is
    // presented as soon as the cycle count reaches c + latency.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q1.delete();
            q2.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            rvalid2     <= 1'b0;
            rdata2      <= 32'h0;
        end else begin
            cyc = cyc + 1;
            if (imem_rvalid) void'(q1.pop_front());
            if (imem_req && imem_gnt) q1.push_back('{imem_addr, cyc + latency});
            if (q1.size() > 0 && q1[0].due <= cyc + 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word(q1[0].addr);
            end else begin
                imem_rvalid <= 1'b0;
            end
            if (rvalid2) void'(q2.pop_front());
            if (req2 && imem_gnt) q2.push_back('{addr2, cyc + latency});
            if (q2.size() > 0 && q2[0].due <= cyc + 1) begin
                rvalid2 <= 1'b1;
                rdata2  <= word(q2[0].addr);
            end else begin
                rvalid2 <= 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        stallD    = 1'b0;
        pcsrcD    = 1'b0;
        jumpD     = 1'b0;
        pcbranchD = 32'h0;
        jumpdstD  = 28'h0;
        pcplus4D  = 32'h0;
        imem_gnt  = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        resetDut();
        assertCount++; if (imem_req !== 1'b1) begin failCount++; $display("FAIL reset_req got %b expected 1", imem_req); end
        assertCount++; if (imem_addr !== 32'h0) begin failCount++; $display("FAIL reset_addr got %h expected 0", imem_addr); end
        assertCount++; if (instrF !== 32'h0) begin failCount++; $display("FAIL reset_instr got %h expected 0", instrF); end
        assertCount++; if (pcplus4F !== 32'h0) begin failCount++; $display("FAIL reset_pcp4 got %h expected 0", pcplus4F); end
        assertCount++; if (emptyF !== 1'b1) begin failCount++; $display("FAIL reset_empty got %b expected 1", emptyF); end
    endtask

    task automatic test_stream();
        latency = 1;
        resetDut();
        for (int k = 1; k <= 8; k++) begin
            step();
            assertCount++; if (imem_addr !== 32'(4 * k)) begin failCount++; $display("FAIL stream_addr[%0d] got %h expected %h", k, imem_addr, 32'(4 * k)); end
            if (k == 1) begin
                assertCount++; if (instrF !== 32'h0) begin failCount++; $display("FAIL stream_bubble got %h expected 0", instrF); end
            end else begin
                assertCount++; if (instrF !== word(32'(4 * (k - 2)))) begin failCount++; $display("FAIL stream_instr[%0d] got %h expected %h", k, instrF, word(32'(4 * (k - 2)))); end
                assertCount++; if (pcplus4F !== 32'(4 * (k - 1))) begin failCount++; $display("FAIL stream_pcp4[%0d] got %h expected %h", k, pcplus4F, 32'(4 * (k - 1))); end
            end
        end
    endtask

    task automatic test_stall_full();
        int issues = 0;
        latency = 1;
        resetDut();
        stallD = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_gnt) issues++;
            step();
        end
        assertCount++; if (issues !== 4) begin failCount++; $display("FAIL stall_issues got %0d expected 4", issues); end
        assertCount++; if (imem_req !== 1'b0) begin failCount++; $display("FAIL stall_req got %b expected 0", imem_req); end
        assertCount++; if (instrF !== word(32'h0)) begin failCount++; $display("FAIL stall_hold got %h expected %h", instrF, word(32'h0)); end
        stallD = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            assertCount++; if (instrF !== word(32'(4 * i))) begin failCount++; $display("FAIL drain_instr[%0d] got %h expected %h", i, instrF, word(32'(4 * i))); end
            assertCount++; if (pcplus4F !== 32'(4 * i + 4)) begin failCount++; $display("FAIL drain_pcp4[%0d] got %h expected %h", i, pcplus4F, 32'(4 * i + 4)); end
            step();
        end
    endtask

    task automatic test_branch_inflight();
        int guard = 0;
        latency = 3;
        resetDut();
        step();
        step();
        pcsrcD    = 1'b1;
        pcbranchD = 32'h100;
        #1;
        assertCount++; if (instrF !== 32'h0) begin failCount++; $display("FAIL br_instr got %h expected 0", instrF); end
        assertCount++; if (imem_req !== 1'b0) begin failCount++; $display("FAIL br_req got %b expected 0", imem_req); end
        step();
        pcsrcD = 1'b0;
        #1;
        assertCount++; if (imem_addr !== 32'h100) begin failCount++; $display("FAIL br_addr got %h expected 00000100", imem_addr); end
        while (instrF === 32'h0 && guard < 20) begin
            step();
            guard++;
        end
        assertCount++; if (instrF !== word(32'h100)) begin failCount++; $display("FAIL br_first got %h expected %h", instrF, word(32'h100)); end
        assertCount++; if (pcplus4F !== 32'h104) begin failCount++; $display("FAIL br_pcp4 got %h expected 00000104", pcplus4F); end
    endtask

    task automatic test_jump();
        latency = 1;
        resetDut();
        step();
        step();
        step();
        jumpD     = 1'b1;
        pcsrcD    = 1'b1;
        pcbranchD = 32'h200;
        pcplus4D  = 32'h4000_0010;
        jumpdstD  = 28'h0000040;
        #1;
        assertCount++; if (instrF !== 32'h0) begin failCount++; $display("FAIL jmp_instr got %h expected 0", instrF); end
        assertCount++; if (pcplus4F !== 32'h0) begin failCount++; $display("FAIL jmp_pcp4 got %h expected 0", pcplus4F); end
        step();
        jumpD  = 1'b0;
        pcsrcD = 1'b0;
        #1;
        assertCount++; if (imem_addr !== 32'h4000_0040) begin failCount++; $display("FAIL jmp_addr got %h expected 40000040", imem_addr); end
        step();
        step();
        assertCount++; if (instrF !== word(32'h4000_0040)) begin failCount++; $display("FAIL jmp_first got %h expected %h", instrF, word(32'h4000_0040)); end
        assertCount++; if (pcplus4F !== 32'h4000_0044) begin failCount++; $display("FAIL jmp_first_pcp4 got %h expected 40000044", pcplus4F); end
    endtask

    task automatic test_stall_redirect();
        latency = 1;
        resetDut();
        step();
        step();
        step();
        stallD    = 1'b1;
        pcsrcD    = 1'b1;
        pcbranchD = 32'h300;
        #1;
        assertCount++; if (instrF !== word(32'h4)) begin failCount++; $display("FAIL sr_instr got %h expected %h", instrF, word(32'h4)); end
        assertCount++; if (imem_addr !== 32'hC) begin failCount++; $display("FAIL sr_addr got %h expected 0000000c", imem_addr); end
        step();
        step();
        assertCount++; if (instrF !== word(32'h4)) begin failCount++; $display("FAIL sr_hold got %h expected %h", instrF, word(32'h4)); end
        assertCount++; if (imem_addr !== 32'h14) begin failCount++; $display("FAIL sr_pc got %h expected 00000014", imem_addr); end
        stallD = 1'b0;
        #1;
        assertCount++; if (instrF !== 32'h0) begin failCount++; $display("FAIL sr_release_instr got %h expected 0", instrF); end
        step();
        pcsrcD = 1'b0;
        #1;
        assertCount++; if (imem_addr !== 32'h300) begin failCount++; $display("FAIL sr_target got %h expected 00000300", imem_addr); end
        assertCount++; if (emptyF !== 1'b1) begin failCount++; $display("FAIL sr_flush got %b expected 1", emptyF); end
        step();
        step();
        assertCount++; if (instrF !== word(32'h300)) begin failCount++; $display("FAIL sr_first got %h expected %h", instrF, word(32'h300)); end
        assertCount++; if (pcplus4F !== 32'h304) begin failCount++; $display("FAIL sr_first_pcp4 got %h expected 00000304", pcplus4F); end
    endtask

    task automatic test_wrap_and_reset();
        latency = 1;
        resetDut();
        assertCount++; if (addr2 !== 32'hFFFF_FFF8) begin failCount++; $display("FAIL wrap_addr0 got %h expected fffffff8", addr2); end
        step();
        assertCount++; if (addr2 !== 32'hFFFF_FFFC) begin failCount++; $display("FAIL wrap_addr1 got %h expected fffffffc", addr2); end
        step();
        assertCount++; if (addr2 !== 32'h0) begin failCount++; $display("FAIL wrap_addr2 got %h expected 0", addr2); end
        assertCount++; if (pcp2 !== 32'hFFFF_FFFC) begin failCount++; $display("FAIL wrap_pcp4a got %h expected fffffffc", pcp2); end
        step();
        assertCount++; if (instr2 !== word(32'hFFFF_FFFC)) begin failCount++; $display("FAIL wrap_instr got %h expected %h", instr2, word(32'hFFFF_FFFC)); end
        assertCount++; if (pcp2 !== 32'h0) begin failCount++; $display("FAIL wrap_pcp4b got %h expected 0", pcp2); end
        step();
        reset = 1'b1;
        #1;
        assertCount++; if (instr2 !== 32'h0) begin failCount++; $display("FAIL midrst_instr got %h expected 0", instr2); end
        assertCount++; if (addr2 !== 32'hFFFF_FFF8) begin failCount++; $display("FAIL midrst_addr got %h expected fffffff8", addr2); end
        assertCount++; if (empty2 !== 1'b1) begin failCount++; $display("FAIL midrst_empty got %b expected 1", empty2); end
        assertCount++; if (imem_addr !== 32'h0) begin failCount++; $display("FAIL midrst_addr_main got %h expected 0", imem_addr); end
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_stream();
        test_stall_full();
        test_branch_inflight();
        test_jump();
        test_stall_redirect();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
